enigma_core: RTL and testbench
==============================

Name: enigma_core

Overview:
Consumer of the config/letter command stream produced by the switch-input data module. Implements a 3-rotor Enigma (rotors I–VIII selectable, fixed reflector, no plugboard, ring settings fixed at A):
- loads rotor selection and start positions on rotor_valid_in;
- on each letter_valid_in pulse, steps the rotors and time-shares one rotor-traversal datapath over 7 passes;
- emits one enciphered letter with a valid pulse to downstream display/UART logic.

Parameters:
REFLECTOR_SEL, 0, 0 = UKW-B, 1 = UKW-C; fixed at elaboration.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
rotor_valid_in  input  1  one-cycle pulse; load rotor config
rotor_select_in  input  9  [8:6] left, [5:3] middle, [2:0] right rotor code (0=I … 7=VIII)
rotor_initial_in  input  15  [14:10] left, [9:5] middle, [4:0] right start position (0=A)
letter_valid_in  input  1  one-cycle pulse; encipher char_in
char_in  input  5  plaintext letter 0–25
char_out  output  5  enciphered letter
char_valid_out  output  1  one-cycle pulse; char_out valid
busy_out  output  1  high whenever FSM not IDLE
rotor_pos_out  output  15  current {left, mid, right} positions, for display
drop_out  output  1  one-cycle pulse; letter rejected

Behaviour:
- Reset (async assert, sync release) sets:
  - char_out=0, char_valid_out=0, drop_out=0, busy_out=0
  - all rotor selects=0 (rotor I)
  - rotor_pos_out=0
  - FSM=IDLE
- Config load:
  - rotor_valid_in sampled high in any state latches select and positions at that edge.
  - Each 5-bit position ≥26 is reduced by 26 (26→0 … 31→5).
  - If the FSM is not IDLE, the in-flight letter is aborted: no char_valid_out, FSM→IDLE.
  - Config load has priority over letter_valid_in in the same cycle; that letter is dropped (drop_out pulse).
- Letter accept:
  - Only in IDLE, with char_in ≤25.
  - char_in ≥26: drop_out pulse, no stepping, stays IDLE.
  - letter_valid_in while busy (not a config load): drop_out pulse, current letter unaffected.
- FSM: IDLE → STEP → F_R → F_M → F_L → REFL → B_L → B_M → B_R → IDLE.
  - Latched letter is held in a 5-bit working register.
- STEP: positions updated once, before enciphering (Enigma rule).
  - Right always advances.
  - Middle advances if right is at its notch, or middle is at its notch (double step).
  - Left advances if middle is at its notch.
  - Notch positions tested pre-step: I=16, II=4, III=21, IV=9, V=25, VI/VII/VIII = 25 and 12.
  - Positions wrap 25→0.
- Forward pass through rotor with position p: out = (W[(in+p) mod 26] − p) mod 26.
- Backward pass: same form using the inverse table.
- REFL: out = reflector table[in].
- All mod-26 arithmetic is done on 6-bit intermediates with a single conditional add/subtract of 26; no divider.
- Latency: letter sampled at edge N → rotor_pos_out updated after edge N+1 → char_out valid and char_valid_out high for exactly the cycle following edge N+8.
  - FSM returns to IDLE at that same edge, so a letter presented during the char_valid_out cycle is accepted.
- char_out holds its value until the next valid pulse.
- busy_out is a registered decode of state != IDLE.

Decomposition:
- Package enigma_pkg holds:
  - forward wiring tables for rotors I–VIII (8×26×5 bits);
  - inverse tables;
  - notch table (two notch values per rotor; single-notch rotors duplicate the value);
  - reflector B/C tables;
  - FSM state enum;
  - a mod-26 add/subtract function.
- One sub-module, enigma_rotor_pass: combinational single-rotor traversal.
  - Inputs: rotor code, position, direction, letter. Output: letter.
  - Instantiated once and time-shared by the FSM.

Test Plan:
- Config select=9'h00A (I-II-III), initial=0, then letters A,A,A,A,A at 12-cycle spacing → char_out B,D,Z,G,O (1,3,25,6,14); rotor_pos_out ends 15'h0005.
- Same rotors, initial {0,3,20} (ADU), three letters → positions ADV, AEW, BFX (double step) after each STEP.
- Reciprocity: random plaintext of 50 letters at start XYZ, reload XYZ, feed ciphertext → original plaintext; no letter ever maps to itself.
- Letter at N, second letter at N+3 → drop_out at N+4, first result still at N+9; a letter at the char_valid_out cycle is accepted.
- rotor_valid_in during F_M → no char_valid_out, new config on rotor_pos_out, busy_out low next cycle; char_in=27 in IDLE → drop_out, positions unchanged.
- Async rst_in mid-B_L (between clock edges) → all outputs zero immediately, no stray char_valid_out after release; initial value 31 on load → position 5.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared tables, state encoding and mod-26 helper for the enigma_core datapath.
// Wiring tables are elaborated from the historical letter strings so they can be checked against reference sheets.
package enigma_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_STEP, ST_F_R, ST_F_M, ST_F_L, ST_REFL, ST_B_L, ST_B_M, ST_B_R
  } state_t;

  typedef logic [25:0][4:0]       perm_t;
  typedef logic [7:0][25:0][4:0]  rotor_tbl_t;
  typedef logic [7:0][1:0][4:0]   notch_tbl_t;

  // Listed VIII down to I so that index 0 is rotor I.
  localparam logic [7:0][207:0] ROTOR_STR = {
    "FKQHTLXOCBJSPDZRAMEWNIUYGV", "NZJHGRCXMYSWBOUFAIVLPEKQDT",
    "JPGVOUMFYQBENHZRDKASXLICTW", "VZBRGITYUPSDNHLXAWMJQOFECK",
    "ESOVPZJAYQUIRHXLNFTGKDCMWB", "BDFHJLCPRTXVZNYEIWGAKMUSQO",
    "AJDKSIRUXBLHWTMCQGZNPYFVOE", "EKMFLGDQVZNTOWYHXUSPAIBRCJ"
  };

  function automatic perm_t str_to_perm(input logic [207:0] s);
    perm_t p;
    for (int i = 0; i < 26; i++) p[i] = 5'(s[8*(25-i) +: 8] - 8'd65);
    return p;
  endfunction

  function automatic rotor_tbl_t build_fwd();
    rotor_tbl_t t;
    for (int c = 0; c < 8; c++) t[c] = str_to_perm(ROTOR_STR[c]);
    return t;
  endfunction

  function automatic rotor_tbl_t build_inv();
    rotor_tbl_t f;
    rotor_tbl_t t;
    f = build_fwd();
    t = '0;
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 26; i++) t[c][f[c][i]] = 5'(i);
    return t;
  endfunction

  localparam rotor_tbl_t ROTOR_FWD = build_fwd();
  localparam rotor_tbl_t ROTOR_INV = build_inv();

  // Two notches per rotor; single-notch rotors repeat their value. Order: VIII..I.
  localparam notch_tbl_t NOTCH = {
    5'd25, 5'd12,  5'd25, 5'd12,  5'd25, 5'd12,  5'd25, 5'd25,
    5'd9,  5'd9,   5'd21, 5'd21,  5'd4,  5'd4,   5'd16, 5'd16
  };

  localparam perm_t REFL_B = str_to_perm("YRUHQSLDPXNGOKMIEBFZCWVJAT");
  localparam perm_t REFL_C = str_to_perm("FVPJIAOYEDRZXWGCTKUQSBNMHL");

  // Operands must already be in 0..25; one correction of 26 is then sufficient.
  function automatic logic [4:0] mod26_addsub(input logic [4:0] a, input logic [4:0] b,
                                              input logic sub);
    logic [5:0] t;
    if (sub) begin
      t = {1'b0, a} - {1'b0, b};
      if (t[5]) t = t + 6'd26;
    end else begin
      t = {1'b0, a} + {1'b0, b};
      if (t >= 6'd26) t = t - 6'd26;
    end
    return t[4:0];
  endfunction

endpackage

// File: rtl/enigma_rotor_pass.sv
// Combinational traversal of one rotor at a given position, in either direction.
module enigma_rotor_pass
  import enigma_pkg::*;
(
  input  logic [2:0] rotor_sel,
  input  logic [4:0] pos,
  input  logic       backward,
  input  logic [4:0] letter,
  output logic [4:0] result
);

  logic [4:0] contact;
  logic [4:0] wired;

  always_comb begin
    contact = mod26_addsub(letter, pos, 1'b0);
    wired   = backward ? ROTOR_INV[rotor_sel][contact] : ROTOR_FWD[rotor_sel][contact];
    result  = mod26_addsub(wired, pos, 1'b1);
  end

endmodule

// File: rtl/enigma_core.sv
// Three-rotor Enigma: steps on each accepted letter, then walks one shared rotor
// datapath through seven passes (R, M, L, reflector, L, M, R) before emitting the result.
module enigma_core
  import enigma_pkg::*;
#(
  parameter int REFLECTOR_SEL = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rotor_valid_in,
  input  logic [8:0]  rotor_select_in,
  input  logic [14:0] rotor_initial_in,
  input  logic        letter_valid_in,
  input  logic [4:0]  char_in,
  output logic [4:0]  char_out,
  output logic        char_valid_out,
  output logic        busy_out,
  output logic [14:0] rotor_pos_out,
  output logic        drop_out
);

  localparam perm_t REFL = (REFLECTOR_SEL == 0) ? REFL_B : REFL_C;

  state_t     state;
  logic [2:0] sel_l, sel_m, sel_r;
  logic [4:0] pos_l, pos_m, pos_r;
  logic [4:0] work;
  logic [2:0] pass_sel;
  logic [4:0] pass_pos;
  logic       pass_bwd;
  logic [4:0] pass_result;
  logic       notch_r, notch_m;

  function automatic logic [4:0] fold26(input logic [4:0] p);
    return (p >= 5'd26) ? p - 5'd26 : p;
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic at_notch(input logic [2:0] r, input logic [4:0] p);
    return (p == NOTCH[r][0]) || (p == NOTCH[r][1]);
  endfunction

  assign notch_r       = at_notch(sel_r, pos_r);
  assign notch_m       = at_notch(sel_m, pos_m);
  assign rotor_pos_out = {pos_l, pos_m, pos_r};

  always_comb begin
    pass_sel = sel_r;
    pass_pos = pos_r;
    pass_bwd = 1'b0;
    case (state)
      ST_F_M: begin pass_sel = sel_m; pass_pos = pos_m; end
      ST_F_L: begin pass_sel = sel_l; pass_pos = pos_l; end
      ST_B_L: begin pass_sel = sel_l; pass_pos = pos_l; pass_bwd = 1'b1; end
      ST_B_M: begin pass_sel = sel_m; pass_pos = pos_m; pass_bwd = 1'b1; end
      ST_B_R: pass_bwd = 1'b1;
      default: ;
    endcase
  end

  enigma_rotor_pass u_pass (
    .rotor_sel (pass_sel),
    .pos       (pass_pos),
    .backward  (pass_bwd),
    .letter    (work),
    .result    (pass_result)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= ST_IDLE;
      sel_l          <= '0;
      sel_m          <= '0;
      sel_r          <= '0;
      pos_l          <= '0;
      pos_m          <= '0;
      pos_r          <= '0;
      work           <= '0;
      char_out       <= '0;
      char_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      drop_out       <= 1'b0;
    end else begin
      char_valid_out <= 1'b0;
      drop_out       <= 1'b0;
      if (rotor_valid_in) begin
        // Config wins: any in-flight letter is abandoned and a same-cycle letter is rejected.
        sel_l    <= rotor_select_in[8:6];
        sel_m    <= rotor_select_in[5:3];
        sel_r    <= rotor_select_in[2:0];
        pos_l    <= fold26(rotor_initial_in[14:10]);
        pos_m    <= fold26(rotor_initial_in[9:5]);
        pos_r    <= fold26(rotor_initial_in[4:0]);
        state    <= ST_IDLE;
        busy_out <= 1'b0;
        drop_out <= letter_valid_in;
      end else begin
        if (letter_valid_in && (state != ST_IDLE || char_in > 5'd25)) drop_out <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (letter_valid_in && char_in <= 5'd25) begin
              work     <= char_in;
              state    <= ST_STEP;
              busy_out <= 1'b1;
            end
          end
          ST_STEP: begin
            pos_r <= inc26(pos_r);
            if (notch_r || notch_m) pos_m <= inc26(pos_m);
            if (notch_m) pos_l <= inc26(pos_l);
            state <= ST_F_R;
          end
          ST_F_R: begin work <= pass_result; state <= ST_F_M; end
          ST_F_M: begin work <= pass_result; state <= ST_F_L; end
          ST_F_L: begin work <= pass_result; state <= ST_REFL; end
          ST_REFL: begin work <= REFL[work]; state <= ST_B_L; end
          ST_B_L: begin work <= pass_result; state <= ST_B_M; end
          ST_B_M: begin work <= pass_result; state <= ST_B_R; end
          ST_B_R: begin
            char_out       <= pass_result;
            char_valid_out <= 1'b1;
            state          <= ST_IDLE;
            busy_out       <= 1'b0;
          end
          default: begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enigma_core.sv
// Bench for enigma_core: vector table, hand-built timing corners and random traffic
// checked against a letter-string Enigma model.
module tb_enigma_core;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rotor_valid_in;
  logic [8:0]  rotor_select_in;
  logic [14:0] rotor_initial_in;
  logic        letter_valid_in;
  logic [4:0]  char_in;
  logic [4:0]  char_out;
  logic        char_valid_out;
  logic        busy_out;
  logic [14:0] rotor_pos_out;
  logic        drop_out;

  enigma_core #(.REFLECTOR_SEL(0)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rotor_valid_in   (rotor_valid_in),
    .rotor_select_in  (rotor_select_in),
    .rotor_initial_in (rotor_initial_in),
    .letter_valid_in  (letter_valid_in),
    .char_in          (char_in),
    .char_out         (char_out),
    .char_valid_out   (char_valid_out),
    .busy_out         (busy_out),
    .rotor_pos_out    (rotor_pos_out),
    .drop_out         (drop_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  string ROT [8] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                     "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                     "VZBRGITYUPSDNHLXAWMJQOFECK", "JPGVOUMFYQBENHZRDKASXLICTW",
                     "NZJHGRCXMYSWBOUFAIVLPEKQDT", "FKQHTLXOCBJSPDZRAMEWNIUYGV"};
  string NOTCHES [8] = '{"Q", "E", "V", "J", "Z", "ZM", "ZM", "ZM"};
  string REFB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int m_sel [3];  // 0 = left, 1 = middle, 2 = right
  int m_pos [3];

  function automatic int lt(input string s, input int i);
    return int'(s[i]) - 65;
  endfunction

  function automatic bit m_at_notch(input int r, input int p);
    for (int i = 0; i < NOTCHES[r].len(); i++) if (lt(NOTCHES[r], i) == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_fwd(input int r, input int p, input int c);
    return (lt(ROT[r], (c + p) % 26) - p + 26) % 26;
  endfunction

  function automatic int m_bwd(input int r, input int p, input int c);
    int x = (c + p) % 26;
    for (int j = 0; j < 26; j++) if (lt(ROT[r], j) == x) return (j - p + 26) % 26;
    return -1;
  endfunction

  function automatic void model_config(input logic [8:0] sel, input logic [14:0] init);
    m_sel[0] = int'(sel[8:6]);  m_sel[1] = int'(sel[5:3]);  m_sel[2] = int'(sel[2:0]);
    m_pos[0] = int'(init[14:10]) % 26;
    m_pos[1] = int'(init[9:5]) % 26;
    m_pos[2] = int'(init[4:0]) % 26;
  endfunction

  function automatic int model_pos();
    return (m_pos[0] << 10) | (m_pos[1] << 5) | m_pos[2];
  endfunction

  function automatic int model_encipher(input int c);
    bit rn, mn;
    int x;
    rn = m_at_notch(m_sel[2], m_pos[2]);
    mn = m_at_notch(m_sel[1], m_pos[1]);
    m_pos[2] = (m_pos[2] + 1) % 26;
    if (rn || mn) m_pos[1] = (m_pos[1] + 1) % 26;
    if (mn) m_pos[0] = (m_pos[0] + 1) % 26;
    x = c;
    for (int k = 2; k >= 0; k--) x = m_fwd(m_sel[k], m_pos[k], x);
    x = lt(REFB, x);
    for (int k = 0; k < 3; k++) x = m_bwd(m_sel[k], m_pos[k], x);
    return x;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_config(input logic [8:0] sel, input logic [14:0] init);
    rotor_valid_in = 1'b1;  rotor_select_in = sel;  rotor_initial_in = init;
    @(negedge clk_in);
    rotor_valid_in = 1'b0;
    model_config(sel, init);
  endtask

  task automatic do_letter(input int c, output int got);
    int exp, lat;
    exp = model_encipher(c);
    letter_valid_in = 1'b1;  char_in = 5'(c);
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    lat = -1;  got = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_in);
      if (char_valid_out) begin lat = k; got = int'(char_out); break; end
    end
    check("latency", lat, 8);
    check("char_out", got, exp);
    check("rotor_pos", int'(rotor_pos_out), model_pos());
    @(negedge clk_in);
    check("valid_one_cycle", int'(char_valid_out), 0);
  endtask

  typedef struct {
    bit          is_cfg;
    logic [8:0]  sel;
    logic [14:0] init;
    int          ch;
    int          exp_ch;   // -1: only the model is consulted
    logic [14:0] exp_pos;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int got, nvalid;
    int pt [50];
    int ct [50];
    logic [8:0]  rsel;
    logic [14:0] rinit;
    int exp1;

    vecs.push_back('{1'b1, 9'h00A, 15'h0000, 0, -1, 15'h0000});
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 0,  1, 15'h0001});
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 0,  3, 15'h0002});
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 0, 25, 15'h0003});
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 0,  6, 15'h0004});
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 0, 14, 15'h0005});
    vecs.push_back('{1'b1, 9'h00A, 15'h0074, 0, -1, 15'h0074});   // ADU
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 0, -1, 15'h0075});   // ADV
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 7, -1, 15'h0096});   // AEW
    vecs.push_back('{1'b0, 9'h000, 15'h0000, 19, -1, 15'h04B7});  // BFX
    vecs.push_back('{1'b1, 9'h0FF, 15'h7FFF, 0, -1, 15'h14A5});   // 31 -> 5 everywhere
    vecs.push_back('{1'b1, 9'h1C5, 15'h6B5A, 0, -1, 15'h0000});   // {26,26,26} -> AAA

    rst_in = 1'b1;  rotor_valid_in = 1'b0;  rotor_select_in = '0;  rotor_initial_in = '0;
    letter_valid_in = 1'b0;  char_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst_char_out", int'(char_out), 0);
    check("rst_valid", int'(char_valid_out), 0);
    check("rst_drop", int'(drop_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_pos", int'(rotor_pos_out), 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Table vectors
    foreach (vecs[i]) begin
      if (vecs[i].is_cfg) begin
        do_config(vecs[i].sel, vecs[i].init);
        check("tbl_cfg_pos", int'(rotor_pos_out), int'(vecs[i].exp_pos));
        check("tbl_cfg_busy", int'(busy_out), 0);
      end else begin
        do_letter(vecs[i].ch, got);
        if (vecs[i].exp_ch >= 0) check("tbl_char", got, vecs[i].exp_ch);
        check("tbl_pos", int'(rotor_pos_out), int'(vecs[i].exp_pos));
      end
    end

    // Reciprocity at XYZ with a random rotor order
    rsel = 9'($urandom_range(0, 511));
    rinit = 15'((23 << 10) | (24 << 5) | 25);
    do_config(rsel, rinit);
    for (int i = 0; i < 50; i++) begin
      pt[i] = int'($urandom_range(0, 25));
      do_letter(pt[i], ct[i]);
      check("no_self_map", int'(ct[i] == pt[i]), 0);
    end
    do_config(rsel, rinit);
    for (int i = 0; i < 50; i++) begin
      do_letter(ct[i], got);
      check("reciprocity", got, pt[i]);
    end

    // Random configurations, including out-of-range start positions
    for (int r = 0; r < 4; r++) begin
      do_config(9'($urandom_range(0, 511)), 15'($urandom_range(0, 32767)));
      check("rand_cfg_pos", int'(rotor_pos_out), model_pos());
      for (int i = 0; i < 10; i++) do_letter(int'($urandom_range(0, 25)), got);
    end

    // Letter while busy is dropped; letter in the valid cycle is accepted
    do_config(9'h00A, 15'h0000);
    exp1 = model_encipher(2);
    letter_valid_in = 1'b1;  char_in = 5'd2;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    nvalid = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (k == 3) begin
        letter_valid_in = 1'b0;
        check("drop_while_busy", int'(drop_out), 1);
      end
      if (k == 4) check("drop_one_cycle", int'(drop_out), 0);
      if (k < 8 && char_valid_out) nvalid++;
      if (k == 2) begin letter_valid_in = 1'b1; char_in = 5'd5; end
    end
    check("no_early_valid", nvalid, 0);
    check("busy_first_valid", int'(char_valid_out), 1);
    check("busy_first_char", int'(char_out), exp1);
    check("busy_low_at_valid", int'(busy_out), 0);
    do_letter(9, got);

    // Config load during F_M aborts the letter
    do_config(9'h00A, 15'h0000);
    letter_valid_in = 1'b1;  char_in = 5'd4;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rotor_valid_in = 1'b1;  rotor_select_in = 9'h1C5;  rotor_initial_in = 15'h0443;
    @(negedge clk_in);
    rotor_valid_in = 1'b0;
    model_config(9'h1C5, 15'h0443);
    check("abort_busy", int'(busy_out), 0);
    check("abort_pos", int'(rotor_pos_out), model_pos());
    nvalid = 0;
    repeat (12) begin @(negedge clk_in); if (char_valid_out) nvalid++; end
    check("abort_no_valid", nvalid, 0);

    // Config and letter together: config wins, letter dropped
    rotor_valid_in = 1'b1;  rotor_select_in = 9'h053;  rotor_initial_in = 15'h2108;
    letter_valid_in = 1'b1;  char_in = 5'd3;
    @(negedge clk_in);
    rotor_valid_in = 1'b0;  letter_valid_in = 1'b0;
    model_config(9'h053, 15'h2108);
    check("cfg_letter_drop", int'(drop_out), 1);
    check("cfg_letter_busy", int'(busy_out), 0);
    check("cfg_letter_pos", int'(rotor_pos_out), model_pos());

    // Out-of-range letter in IDLE
    letter_valid_in = 1'b1;  char_in = 5'd27;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    check("bad_char_drop", int'(drop_out), 1);
    check("bad_char_busy", int'(busy_out), 0);
    check("bad_char_pos", int'(rotor_pos_out), model_pos());
    nvalid = 0;
    repeat (10) begin @(negedge clk_in); if (char_valid_out) nvalid++; end
    check("bad_char_no_valid", nvalid, 0);
    do_letter(11, got);

    // Asynchronous reset while in B_L
    letter_valid_in = 1'b1;  char_in = 5'd17;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    repeat (5) @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("arst_char_out", int'(char_out), 0);
    check("arst_valid", int'(char_valid_out), 0);
    check("arst_busy", int'(busy_out), 0);
    check("arst_drop", int'(drop_out), 0);
    check("arst_pos", int'(rotor_pos_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_config(9'h000, 15'h0000);
    nvalid = 0;
    repeat (12) begin @(negedge clk_in); if (char_valid_out) nvalid++; end
    check("arst_no_stray_valid", nvalid, 0);
    do_letter(0, got);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
